// File: rtl/fifo_pkg.sv
// Shared helpers for the flagged synchronous FIFO: pointer sizing, the
// per-cycle operation encoding and parameter legality checks.
package fifo_pkg;

    // Index bits needed to address 'depth' entries; the wrap bit is added by the user.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // True when depth is a power of two >= 2 and both thresholds are in range.
    function automatic bit params_legal(input int unsigned depth,
                                        input int unsigned af_thresh,
                                        input int unsigned ae_thresh);
        return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
               (af_thresh >= 1) && (af_thresh <= depth) &&
               (ae_thresh <= depth - 1);
    endfunction

    // Accepted operations in one cycle, encoded as {write_ok, read_ok}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_RW   = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_WIDTH storage with one write port and one registered,
// enable-held read port. Contents are never reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 8,
    localparam int unsigned AW        = ptr_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // A same-address read and write returns the old word (read-before-write).
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags and
// a read-valid strobe. Define SYNC_FIFO_ERR_FLAGS_EN for sticky overflow/underflow outputs.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned AF_THRESH  = DEPTH - 2,
    parameter int unsigned AE_THRESH  = 2,
    localparam int unsigned PW        = ptr_w(DEPTH),
    localparam int unsigned CW        = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    typedef logic [PW:0]   ptr_t;
    typedef logic [CW-1:0] cnt_t;

    ptr_t                  r_wr_ptr;
    ptr_t                  r_rd_ptr;
    cnt_t                  r_count;
    cnt_t                  w_count_nxt;
    logic                  r_rd_valid;
    logic                  r_has_data;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic [DATA_WIDTH-1:0] w_ram_rdata;
    fifo_op_e              w_op;

    // Flags decode straight from the count register, so reset clears them at once.
    assign w_full       = (r_count == cnt_t'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= cnt_t'(AF_THRESH));
    assign almost_empty = (r_count <= cnt_t'(AE_THRESH));
    assign count        = r_count;
    assign rd_valid     = r_rd_valid;

    // A read frees a slot in the same cycle, so a full FIFO still takes a paired write.
    assign w_rd_ok = r_en && !w_empty;
    assign w_wr_ok = w_en && (!w_full || w_rd_ok);
    assign w_op    = fifo_op_e'({w_wr_ok, w_rd_ok});

    always_comb begin
        w_count_nxt = r_count;
        case (w_op)
            OP_WR:   w_count_nxt = r_count + cnt_t'(1);
            OP_RD:   w_count_nxt = r_count - cnt_t'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
            r_has_data <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_rd_valid <= w_rd_ok;
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + ptr_t'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr   <= r_rd_ptr + ptr_t'(1);
                r_has_data <= 1'b1;
            end
        end
    end

    fifo_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_ok),
        .i_waddr (r_wr_ptr[PW-1:0]),
        .i_wdata (data_in),
        .i_re    (w_rd_ok),
        .i_raddr (r_rd_ptr[PW-1:0]),
        .o_rdata (w_ram_rdata)
    );

    // The RAM read register has no reset; mask it until a read lands after reset.
    assign data_out = r_has_data ? w_ram_rdata : '0;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_en && w_full && !w_rd_ok) begin
                overflow <= 1'b1;
            end
            if (r_en && w_empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags (DEPTH=8): directed vector table, corner sequences
// and randomized traffic checked against a queue-based reference model.
module tb_sync_fifo_flags;
    import fifo_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned AF    = 6;
    localparam int unsigned AE    = 2;

    logic          clk;
    logic          rst_n;
    logic          w_en;
    logic [DW-1:0] data_in;
    logic          r_en;
    logic [DW-1:0] data_out;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [3:0]    count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    sync_fifo_flags #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .w_en         (w_en),
        .data_in      (data_in),
        .r_en         (r_en),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: contents as a queue plus the last read result.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout;
    bit            m_rv;
    bit            m_ovf;
    bit            m_unf;

    typedef struct {
        bit            w;
        bit            r;
        logic [DW-1:0] d;
        int unsigned   cnt;
        bit            rv;
        logic [DW-1:0] dout;
    } vec_t;
    vec_t tbl[$];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_dout = '0;
        m_rv   = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endfunction

    function automatic void check_all(string tag);
        int unsigned sz;
        sz = mq.size();
        chk({tag, ".count"},        32'(count),        sz);
        chk({tag, ".empty"},        32'(empty),        32'(sz == 0));
        chk({tag, ".full"},         32'(full),         32'(sz == DEPTH));
        chk({tag, ".almost_full"},  32'(almost_full),  32'(sz >= AF));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(sz <= AE));
        chk({tag, ".rd_valid"},     32'(rd_valid),     32'(m_rv));
        chk({tag, ".data_out"},     32'(data_out),     32'(m_dout));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
        chk({tag, ".underflow"},    32'(underflow),    32'(m_unf));
`endif
    endfunction

    // Drive one cycle of requests, advance the model, then check after the edge.
    task automatic apply(input bit w, input bit r, input logic [DW-1:0] d, input string tag);
        int unsigned sz;
        bit rok;
        bit wok;
        w_en    = w;
        r_en    = r;
        data_in = d;
        sz  = mq.size();
        rok = r && (sz > 0);
        wok = w && ((sz < DEPTH) || rok);
        if (w && (sz == DEPTH) && !rok) m_ovf = 1'b1;
        if (r && (sz == 0)) m_unf = 1'b1;
        if (rok) begin
            m_dout = mq.pop_front();
            m_rv   = 1'b1;
        end else begin
            m_rv = 1'b0;
        end
        if (wok) mq.push_back(d);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        if (!params_legal(DEPTH, AF, AE)) begin
            $display("FAIL params_legal act=0 exp=1");
            $fatal(1, "illegal bench parameters");
        end

        rst_n   = 1'b0;
        w_en    = 1'b0;
        r_en    = 1'b0;
        data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all("reset");
        apply(0, 0, 8'h00, "idle");

        // Fill, overfill, full read+write, drain, empty read+write.
        for (int i = 1; i <= 8; i++)
            tbl.push_back('{1'b1, 1'b0, 8'(i), i, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 8'hFF, 8, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 1'b1, 8'hAA, 8, 1'b1, 8'h01});
        for (int i = 2; i <= 8; i++)
            tbl.push_back('{1'b0, 1'b1, 8'h00, 9 - i, 1'b1, 8'(i)});
        tbl.push_back('{1'b0, 1'b1, 8'h00, 0, 1'b1, 8'hAA});
        tbl.push_back('{1'b1, 1'b1, 8'h55, 1, 1'b0, 8'hAA});
        tbl.push_back('{1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h55});
        tbl.push_back('{1'b0, 1'b1, 8'h00, 0, 1'b0, 8'h55});

        foreach (tbl[i]) begin
            apply(tbl[i].w, tbl[i].r, tbl[i].d, "vec");
            chk($sformatf("tbl%0d.count", i), 32'(count),    tbl[i].cnt);
            chk($sformatf("tbl%0d.rv", i),    32'(rd_valid), 32'(tbl[i].rv));
            chk($sformatf("tbl%0d.dout", i),  32'(data_out), 32'(tbl[i].dout));
        end

        // Alternating write/read across several pointer wraps.
        for (int i = 0; i < 20; i++) begin
            apply(1'b1, 1'b0, 8'(8'h30 + i), "wrap_wr");
            chk("wrap_cnt_le1", 32'(count <= 4'd1), 32'd1);
            apply(1'b0, 1'b1, 8'h00, "wrap_rd");
            chk("wrap_dout", 32'(data_out), 32'(8'h30 + i));
        end

        // Asynchronous reset with five entries queued.
        for (int i = 0; i < 5; i++) apply(1'b1, 1'b0, 8'(8'hC0 + i), "pre_rst");
        chk("pre_rst_count", 32'(count), 32'd5);
        #2;
        w_en  = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_empty", 32'(empty), 32'd1);
        chk("async_rst_rv",    32'(rd_valid), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all("post_rst");
        apply(1'b0, 1'b1, 8'h00, "rd_after_rst");
        chk("rd_after_rst_rv", 32'(rd_valid), 32'd0);

        // Randomized traffic: write-heavy phase, then read-heavy phase.
        for (int i = 0; i < 600; i++) begin
            int unsigned wp;
            wp = (i < 300) ? 70 : 30;
            apply($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
                  8'($urandom), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
